// File: rtl/eth_pcs_pkg.sv
// rtl/eth_pcs_pkg.sv - shared 64b/66b PCS receive types and sync header constants
package eth_pcs_pkg;

   localparam logic [1:0] SYNC_DATA = 2'b01;
   localparam logic [1:0] SYNC_CTRL = 2'b10;

   typedef enum logic [1:0] {
      ST_UNLOCKED_TEST = 2'd0,
      ST_SLIP_HIGH     = 2'd1,
      ST_SLIP_LOW      = 2'd2,
      ST_LOCKED        = 2'd3
   } lock_state_e;

   typedef enum logic [1:0] {
      SLIP_IDLE  = 2'd0,
      SLIP_PULSE = 2'd1,
      SLIP_BLANK = 2'd2
   } slip_phase_e;

endpackage

// File: rtl/pcs_rx_block_lock_if.sv
// rtl/pcs_rx_block_lock_if.sv - slip request/timing handshake between lock FSM and bitslip timer
interface pcs_rx_block_lock_if;

   logic slip_start;
   logic slip_high_done;
   logic slip_low_done;
   logic bitslip;

   modport master (
      output slip_start,
      input  slip_high_done,
      input  slip_low_done,
      input  bitslip
   );

   modport slave (
      input  slip_start,
      output slip_high_done,
      output slip_low_done,
      output bitslip
   );

endinterface

// File: rtl/pcs_bitslip_timer.sv
// rtl/pcs_bitslip_timer.sv - registered bitslip pulse followed by a blanking interval
module pcs_bitslip_timer import eth_pcs_pkg::*; #(
   parameter int HIGH_CYCLES = 1,
   parameter int LOW_CYCLES  = 8
) (
   input logic                clk,
   input logic                rst_n,
   pcs_rx_block_lock_if.slave slip_if
);

   localparam int MAX_CYCLES = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   slip_phase_e   phase_q, phase_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          bitslip_q, bitslip_d;

   // The counter holds the cycles remaining in the current phase minus one.
   always_comb begin
      phase_d                = phase_q;
      cnt_d                  = cnt_q;
      bitslip_d              = bitslip_q;
      slip_if.slip_high_done = 1'b0;
      slip_if.slip_low_done  = 1'b0;
      case (phase_q)
         SLIP_IDLE: begin
            if (slip_if.slip_start) begin
               phase_d   = SLIP_PULSE;
               cnt_d     = CW'(HIGH_CYCLES - 1);
               bitslip_d = 1'b1;
            end
         end
         SLIP_PULSE: begin
            if (cnt_q == '0) begin
               slip_if.slip_high_done = 1'b1;
               phase_d                = SLIP_BLANK;
               cnt_d                  = CW'(LOW_CYCLES - 1);
               bitslip_d              = 1'b0;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         SLIP_BLANK: begin
            if (cnt_q == '0) begin
               slip_if.slip_low_done = 1'b1;
               phase_d               = SLIP_IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            phase_d   = SLIP_IDLE;
            bitslip_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q   <= SLIP_IDLE;
         cnt_q     <= '0;
         bitslip_q <= 1'b0;
      end else begin
         phase_q   <= phase_d;
         cnt_q     <= cnt_d;
         bitslip_q <= bitslip_d;
      end
   end

   assign slip_if.bitslip = bitslip_q;

endmodule

// File: rtl/pcs_rx_block_lock.sv
// rtl/pcs_rx_block_lock.sv - 64b/66b receive block lock state machine with bitslip and SERDES reset request
module pcs_rx_block_lock import eth_pcs_pkg::*; #(
   parameter int HDR_WIDTH           = 2,
   parameter int SH_LOCK_COUNT       = 64,
   parameter int SH_INVALID_MAX      = 16,
   parameter int BITSLIP_HIGH_CYCLES = 1,
   parameter int BITSLIP_LOW_CYCLES  = 8,
   parameter int SLIP_RESET_COUNT    = 66
) (
   input  logic                 rx_clk,
   input  logic                 rx_rst,
   input  logic [HDR_WIDTH-1:0] serdes_rx_hdr,
   input  logic                 serdes_rx_hdr_valid,
   output logic                 serdes_rx_bitslip,
   output logic                 serdes_rx_reset_req,
   output logic                 rx_block_lock,
   output logic [4:0]           rx_sh_invalid_count
);

   localparam int SH_W   = $clog2(SH_LOCK_COUNT + 1);
   localparam int SLIP_W = $clog2(SLIP_RESET_COUNT + 1);

   lock_state_e       state_q, state_d;
   logic [SH_W-1:0]   sh_cnt_q, sh_cnt_d;
   logic [4:0]        inv_cnt_q, inv_cnt_d;
   logic [SLIP_W-1:0] slip_cnt_q, slip_cnt_d;
   logic              lock_q, lock_d;
   logic              reset_req_q, reset_req_d;
   logic              enter_slip;
   logic              hdr_ok;
   logic              hdr_bad;
   logic [SH_W-1:0]   sh_cnt_inc;

   pcs_rx_block_lock_if slip_if ();

   pcs_bitslip_timer #(
      .HIGH_CYCLES (BITSLIP_HIGH_CYCLES),
      .LOW_CYCLES  (BITSLIP_LOW_CYCLES)
   ) u_bitslip_timer (
      .clk     (rx_clk),
      .rst_n   (rx_rst),
      .slip_if (slip_if)
   );

   assign hdr_ok     = (serdes_rx_hdr == HDR_WIDTH'(SYNC_DATA)) ||
                       (serdes_rx_hdr == HDR_WIDTH'(SYNC_CTRL));
   assign hdr_bad    = serdes_rx_hdr_valid && !hdr_ok;
   assign sh_cnt_inc = sh_cnt_q + SH_W'(1);

   // In LOCKED, sh_cnt counts every qualified header of the current window.
   always_comb begin
      state_d     = state_q;
      sh_cnt_d    = sh_cnt_q;
      inv_cnt_d   = inv_cnt_q;
      slip_cnt_d  = slip_cnt_q;
      lock_d      = lock_q;
      reset_req_d = 1'b0;
      enter_slip  = 1'b0;
      case (state_q)
         ST_UNLOCKED_TEST: begin
            if (serdes_rx_hdr_valid) begin
               if (!hdr_ok) begin
                  enter_slip = 1'b1;
               end else if (sh_cnt_inc == SH_W'(SH_LOCK_COUNT)) begin
                  state_d    = ST_LOCKED;
                  lock_d     = 1'b1;
                  sh_cnt_d   = '0;
                  inv_cnt_d  = '0;
                  slip_cnt_d = '0;
               end else begin
                  sh_cnt_d = sh_cnt_inc;
               end
            end
         end
         ST_SLIP_HIGH: begin
            if (slip_if.slip_high_done) begin
               state_d = ST_SLIP_LOW;
            end
         end
         ST_SLIP_LOW: begin
            if (slip_if.slip_low_done) begin
               state_d  = ST_UNLOCKED_TEST;
               sh_cnt_d = '0;
            end
         end
         ST_LOCKED: begin
            if (serdes_rx_hdr_valid) begin
               // Lock loss wins even when this header also closes the window.
               if (hdr_bad && (inv_cnt_q >= 5'(SH_INVALID_MAX - 1))) begin
                  enter_slip = 1'b1;
                  lock_d     = 1'b0;
                  inv_cnt_d  = 5'(SH_INVALID_MAX);
               end else if (sh_cnt_inc == SH_W'(SH_LOCK_COUNT)) begin
                  sh_cnt_d  = '0;
                  inv_cnt_d = '0;
               end else begin
                  sh_cnt_d = sh_cnt_inc;
                  if (hdr_bad) begin
                     inv_cnt_d = inv_cnt_q + 5'd1;
                  end
               end
            end
         end
         default: begin
            state_d = ST_UNLOCKED_TEST;
         end
      endcase

      if (enter_slip) begin
         state_d  = ST_SLIP_HIGH;
         sh_cnt_d = '0;
         if (slip_cnt_q == SLIP_W'(SLIP_RESET_COUNT - 1)) begin
            slip_cnt_d  = '0;
            reset_req_d = 1'b1;
         end else begin
            slip_cnt_d = slip_cnt_q + SLIP_W'(1);
         end
      end
   end

   always_ff @(posedge rx_clk or negedge rx_rst) begin
      if (!rx_rst) begin
         state_q     <= ST_UNLOCKED_TEST;
         sh_cnt_q    <= '0;
         inv_cnt_q   <= '0;
         slip_cnt_q  <= '0;
         lock_q      <= 1'b0;
         reset_req_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sh_cnt_q    <= sh_cnt_d;
         inv_cnt_q   <= inv_cnt_d;
         slip_cnt_q  <= slip_cnt_d;
         lock_q      <= lock_d;
         reset_req_q <= reset_req_d;
      end
   end

   assign slip_if.slip_start  = enter_slip;
   assign serdes_rx_bitslip   = slip_if.bitslip;
   assign serdes_rx_reset_req = reset_req_q;
   assign rx_block_lock       = lock_q;
   assign rx_sh_invalid_count = inv_cnt_q;

endmodule

// File: tb/tb_pcs_rx_block_lock.sv
// tb/tb_pcs_rx_block_lock.sv - bench for pcs_rx_block_lock against a cycle-level reference model
module tb_pcs_rx_block_lock;

   localparam int LOCK_N  = 64;
   localparam int INV_MAX = 16;
   localparam int HI_N    = 1;
   localparam int LO_N    = 8;
   localparam int SLIP_N  = 66;

   logic       rx_clk = 1'b0;
   logic       rx_rst = 1'b0;
   logic [1:0] hdr = 2'b01;
   logic       hdr_valid = 1'b0;
   logic       bitslip;
   logic       reset_req;
   logic       block_lock;
   logic [4:0] inv_count;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: slip_left counts remaining cycles of pulse plus blanking.
   bit m_locked;
   bit m_reset_req;
   int m_slip_left;
   int m_run;
   int m_hdrs;
   int m_bad;
   int m_slips;

   bit bad_at [64];
   int placed;
   int pick;
   int n_pulses;
   int pulse_idx [$];
   int slip_high_seen;

   always #5 rx_clk = ~rx_clk;

   pcs_rx_block_lock #(
      .HDR_WIDTH           (2),
      .SH_LOCK_COUNT       (LOCK_N),
      .SH_INVALID_MAX      (INV_MAX),
      .BITSLIP_HIGH_CYCLES (HI_N),
      .BITSLIP_LOW_CYCLES  (LO_N),
      .SLIP_RESET_COUNT    (SLIP_N)
   ) dut (
      .rx_clk              (rx_clk),
      .rx_rst              (rx_rst),
      .serdes_rx_hdr       (hdr),
      .serdes_rx_hdr_valid (hdr_valid),
      .serdes_rx_bitslip   (bitslip),
      .serdes_rx_reset_req (reset_req),
      .rx_block_lock       (block_lock),
      .rx_sh_invalid_count (inv_count)
   );

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check5(input string tag, input logic [4:0] obs, input logic [4:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] good_hdr();
      return ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
   endfunction

   function automatic logic [1:0] bad_hdr();
      return ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11;
   endfunction

   function automatic logic [1:0] any_hdr();
      return 2'($urandom_range(0, 3));
   endfunction

   task automatic model_reset();
      m_locked    = 1'b0;
      m_reset_req = 1'b0;
      m_slip_left = 0;
      m_run       = 0;
      m_hdrs      = 0;
      m_bad       = 0;
      m_slips     = 0;
   endtask

   task automatic model_slip();
      m_slip_left = HI_N + LO_N;
      m_run       = 0;
      m_hdrs      = 0;
      m_slips++;
      if (m_slips == SLIP_N) begin
         m_reset_req = 1'b1;
         m_slips     = 0;
      end
   endtask

   task automatic model_edge(input logic v, input logic [1:0] h);
      bit good;
      good        = (h == 2'b01) || (h == 2'b10);
      m_reset_req = 1'b0;
      if (m_slip_left > 0) begin
         m_slip_left--;
      end else if (v) begin
         if (!m_locked) begin
            if (!good) begin
               model_slip();
            end else begin
               m_run++;
               if (m_run == LOCK_N) begin
                  m_locked = 1'b1;
                  m_run    = 0;
                  m_hdrs   = 0;
                  m_bad    = 0;
                  m_slips  = 0;
               end
            end
         end else begin
            m_hdrs++;
            if (!good) m_bad++;
            if (!good && m_bad == INV_MAX) begin
               m_locked = 1'b0;
               model_slip();
            end else if (m_hdrs == LOCK_N) begin
               m_hdrs = 0;
               m_bad  = 0;
            end
         end
      end
   endtask

   task automatic step(input logic v, input logic [1:0] h);
      hdr_valid = v;
      hdr       = h;
      @(posedge rx_clk);
      model_edge(v, h);
      #1;
      check1("bitslip", bitslip, m_slip_left > LO_N);
      check1("block_lock", block_lock, m_locked);
      check1("reset_req", reset_req, m_reset_req);
      check5("inv_count", inv_count, 5'(m_bad));
   endtask

   task automatic check_all_zero(input string tag);
      check1({tag, "_bitslip"}, bitslip, 1'b0);
      check1({tag, "_lock"}, block_lock, 1'b0);
      check1({tag, "_reset_req"}, reset_req, 1'b0);
      check5({tag, "_inv"}, inv_count, 5'd0);
   endtask

   initial begin
      model_reset();
      #22;
      check_all_zero("reset");
      rx_rst = 1'b1;

      // Constant valid control headers from reset lock after exactly 64.
      slip_high_seen = 0;
      for (int i = 0; i < LOCK_N - 1; i++) begin
         step(1'b1, 2'b10);
         if (bitslip) slip_high_seen++;
      end
      check1("acq_lock_before_64", block_lock, 1'b0);
      step(1'b1, 2'b10);
      check1("acq_lock_at_64", block_lock, 1'b1);
      check_int("acq_no_bitslip", slip_high_seen, 0);

      // 15 invalid headers scattered through one window, with valid gaps.
      for (int i = 0; i < 64; i++) bad_at[i] = 1'b0;
      placed = 0;
      while (placed < INV_MAX - 1) begin
         pick = int'($urandom_range(0, 63));
         if (!bad_at[pick]) begin
            bad_at[pick] = 1'b1;
            placed++;
         end
      end
      for (int i = 0; i < LOCK_N; i++) begin
         if ($urandom_range(0, 3) == 0) step(1'b0, any_hdr());
         step(1'b1, bad_at[i] ? bad_hdr() : good_hdr());
      end
      check1("win15_lock_held", block_lock, 1'b1);
      check5("win15_count_cleared", inv_count, 5'd0);

      // 16th invalid header is also the last of the window: lock loss wins.
      for (int i = 0; i < LOCK_N - INV_MAX; i++) step(1'b1, good_hdr());
      for (int i = 0; i < INV_MAX - 1; i++) step(1'b1, bad_hdr());
      check1("win16_lock_before", block_lock, 1'b1);
      check5("win16_count_15", inv_count, 5'd15);
      step(1'b1, bad_hdr());
      check1("win16_lock_drop", block_lock, 1'b0);
      check1("win16_bitslip", bitslip, 1'b1);
      check5("win16_count_sat", inv_count, 5'(INV_MAX));
      for (int i = 0; i < HI_N + LO_N; i++) step(1'b1, good_hdr());

      // Invalid 10th header while unlocked: one pulse, 8 blank, 64 more to lock.
      for (int i = 0; i < 9; i++) step(1'b1, good_hdr());
      step(1'b1, 2'b00);
      check1("slip10_pulse", bitslip, 1'b1);
      slip_high_seen = 0;
      for (int i = 0; i < HI_N + LO_N; i++) begin
         step(1'b1, good_hdr());
         if (bitslip) slip_high_seen++;
      end
      check_int("slip10_blank_low", slip_high_seen, 0);
      for (int i = 0; i < LOCK_N - 1; i++) step(1'b1, good_hdr());
      check1("slip10_no_early_lock", block_lock, 1'b0);
      step(1'b1, good_hdr());
      check1("slip10_lock_at_64", block_lock, 1'b1);

      // Lose lock, then assert reset in the middle of the blanking interval.
      for (int i = 0; i < INV_MAX; i++) step(1'b1, bad_hdr());
      for (int i = 0; i < 4; i++) step(1'b1, good_hdr());
      check5("pre_reset_count", inv_count, 5'(INV_MAX));
      rx_rst = 1'b0;
      #1;
      check_all_zero("rst_slip_low");
      model_reset();
      @(posedge rx_clk);
      #1;
      check_all_zero("rst_held");
      rx_rst = 1'b1;

      // Valid gaps freeze the header count during acquisition.
      for (int i = 0; i < LOCK_N; i++) begin
         if ($urandom_range(0, 1) == 0) step(1'b0, any_hdr());
         if ($urandom_range(0, 2) == 0) step(1'b0, bad_hdr());
         if (i == LOCK_N - 1) check1("gap_no_early_lock", block_lock, 1'b0);
         step(1'b1, good_hdr());
      end
      check1("gap_lock_at_64", block_lock, 1'b1);

      // Reset during the bitslip pulse clears it without a clock edge.
      for (int i = 0; i < INV_MAX; i++) step(1'b1, bad_hdr());
      check1("pulse_before_reset", bitslip, 1'b1);
      rx_rst = 1'b0;
      #1;
      check_all_zero("rst_slip_high");
      model_reset();
      @(posedge rx_clk);
      #1;
      rx_rst = 1'b1;

      // Constant 2'b11: reset request at every 66th slip.
      n_pulses = 0;
      for (int i = 0; i < 2 * SLIP_N * (HI_N + LO_N + 1); i++) begin
         step(1'b1, 2'b11);
         if (reset_req) begin
            n_pulses++;
            pulse_idx.push_back(i);
         end
      end
      check_int("rstreq_pulses", n_pulses, 2);
      if (pulse_idx.size() == 2) begin
         check_int("rstreq_first", pulse_idx[0], (SLIP_N - 1) * (HI_N + LO_N + 1));
         check_int("rstreq_second", pulse_idx[1], (2 * SLIP_N - 1) * (HI_N + LO_N + 1));
      end

      // Random traffic alternating clean and noisy stretches.
      for (int seg = 0; seg < 24; seg++) begin
         for (int i = 0; i < 90; i++) begin
            if ((seg % 2) == 0) begin
               step($urandom_range(0, 7) != 0, good_hdr());
            end else begin
               step($urandom_range(0, 7) != 0,
                    ($urandom_range(0, 4) == 0) ? bad_hdr() : good_hdr());
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pcs_rx_block_lock.md
PCS_RX_BLOCK_LOCK -- requirements
Module: pcs_rx_block_lock

Interface
REQ-001 SHALL have parameter HDR_WIDTH, default 2: width of the 64b/66b sync header.
REQ-002 SHALL have parameter SH_LOCK_COUNT, default 64: number of consecutive valid headers required to reach lock.
REQ-003 SHALL have parameter SH_INVALID_MAX, default 16: number of invalid headers within one window that loses lock.
REQ-004 SHALL have parameter BITSLIP_HIGH_CYCLES, default 1: width of the bitslip pulse in cycles.
REQ-005 SHALL have parameter BITSLIP_LOW_CYCLES, default 8: number of blanking cycles after a bitslip pulse.
REQ-006 SHALL have parameter SLIP_RESET_COUNT, default 66: number of consecutive slips without lock before a SERDES reset request.
REQ-007 SHALL have port rx_clk, input, 1 bit: the single clock.
REQ-008 SHALL have port rx_rst, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port serdes_rx_hdr, input, HDR_WIDTH bits: received sync header.
REQ-010 SHALL have port serdes_rx_hdr_valid, input, 1 bit: serdes_rx_hdr is qualified this cycle.
REQ-011 SHALL have port serdes_rx_bitslip, output, 1 bit: slip request to the SERDES.
REQ-012 SHALL have port serdes_rx_reset_req, output, 1 bit: one-cycle SERDES reset request.
REQ-013 SHALL have port rx_block_lock, output, 1 bit: block lock achieved.
REQ-014 SHALL have port rx_sh_invalid_count, output, 5 bits: invalid headers counted in the current locked window.

Function
REQ-015 SHALL treat a header as valid only when it equals 2'b01 or 2'b10; 2'b00 and 2'b11 are invalid.
REQ-016 SHALL evaluate headers only in cycles where serdes_rx_hdr_valid=1, and SHALL freeze all counters in every other cycle.
REQ-017 SHALL implement four states: UNLOCKED_TEST, SLIP_HIGH, SLIP_LOW, LOCKED.
REQ-018 SHALL, in UNLOCKED_TEST, increment sh_cnt on each valid header.
REQ-019 SHALL, in UNLOCKED_TEST, move to LOCKED with rx_block_lock=1 in the cycle after sh_cnt reaches SH_LOCK_COUNT.
REQ-020 SHALL, in UNLOCKED_TEST, move to SLIP_HIGH in the cycle after any invalid header.
REQ-021 SHALL, in SLIP_HIGH, drive serdes_rx_bitslip=1 for exactly BITSLIP_HIGH_CYCLES cycles, then go to SLIP_LOW.
REQ-022 SHALL, in SLIP_LOW, drive serdes_rx_bitslip=0 and ignore headers for exactly BITSLIP_LOW_CYCLES cycles, then go to UNLOCKED_TEST with sh_cnt=0.
REQ-023 SHALL, in LOCKED, count every qualified header in a window of SH_LOCK_COUNT headers and count invalid headers in rx_sh_invalid_count.
REQ-024 SHALL, in LOCKED, clear rx_block_lock and go to SLIP_HIGH in the cycle after the invalid count reaches SH_INVALID_MAX.
REQ-025 SHALL, in LOCKED, restart the window and clear both counters at window end while remaining locked.
REQ-026 SHALL, when the last header of a window is also the SH_INVALID_MAX-th invalid header, give lock loss priority over the window restart.
REQ-027 SHALL maintain slip_cnt, incremented on each entry to SLIP_HIGH and cleared on reaching LOCKED.
REQ-028 SHALL, when slip_cnt reaches SLIP_RESET_COUNT, pulse serdes_rx_reset_req for 1 cycle and clear slip_cnt.
REQ-029 SHALL drive all outputs from registers; latency from header to status SHALL be 1 cycle.
REQ-030 SHALL saturate rx_sh_invalid_count at SH_INVALID_MAX.

Reset
REQ-031 SHALL, while rx_rst=0, immediately force state UNLOCKED_TEST, all counters 0, and serdes_rx_bitslip, serdes_rx_reset_req and rx_block_lock to 0, including when reset is asserted mid-slip.
REQ-032 SHALL resume header evaluation on the first rx_clk edge after rx_rst is released.

Structure
REQ-033 SHALL place the state encoding and the sync header constants (SYNC_DATA=2'b01, SYNC_CTRL=2'b10) in the shared package eth_pcs_pkg.
REQ-034 SHALL implement the bitslip high/low timing in one sub-module, pcs_bitslip_timer.

Verification
REQ-035 SHALL cover: hdr=2'b10 held valid from reset -> rx_block_lock=1 one cycle after the 64th header; bitslip stays 0.
REQ-036 SHALL cover: unlocked, hdr=2'b00 at the 10th header -> bitslip=1 for 1 cycle, 8 blank cycles, then lock only after 64 further valid headers.
REQ-037 SHALL cover: locked, 15 invalid headers in a window -> lock is held and the count returns to 0 at window end.
REQ-038 SHALL cover: locked, 16 invalid headers in a window -> lock drops the cycle after the 16th and a bitslip pulse follows.
REQ-039 SHALL cover: hdr=2'b11 held constantly -> serdes_rx_reset_req pulses once at the 66th slip, then the slip count restarts.
REQ-040 SHALL cover: rx_rst asserted during SLIP_LOW -> all outputs are 0 with no clock edge; serdes_rx_hdr_valid=0 gaps freeze sh_cnt.
